// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
// f_rr_next is the behavioural reference for the circular search done by rr_pick.
package rr_arb_pkg;

  localparam int BEATS_W = 8;
  localparam int MAX_REQ = 16;

  // First valid index at or after start, wrapping at num_req.
  function automatic logic [3:0] f_rr_next(
    input logic [MAX_REQ-1:0] valid,
    input logic [3:0]         start,
    input int                 num_req
  );
    logic [3:0] result;
    int         k;
    result = start;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < num_req) begin
        k = (int'(start) + i) % num_req;
        if (valid[k]) begin
          result = 4'(k);
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority encoder: first set bit of req at or after
// start, wrapping around, using a doubled request vector masked below start.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   start,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   idx,
  output logic               any
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] mask;
  logic [2*NUM_REQ-1:0] masked;
  logic                 found;

  assign dbl = {req, req};

  // The upper copy is never masked, so the search always wraps back to start.
  for (genvar gi = 0; gi < 2 * NUM_REQ; gi++) begin : g_mask
    assign mask[gi] = (gi >= int'(start));
  end

  assign masked = dbl & mask;
  assign any    = |req;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 2 * NUM_REQ; i++) begin
      if (!found && masked[i]) begin
        found = 1'b1;
        idx   = SEL_W'(i % NUM_REQ);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (found) begin
      grant[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter sharing one registered output stage between NUM_REQ
// bypass FIFOs, with a bounded burst so an owner may keep up to MAX_BURST beats.
module rr_grant_arbiter
  import rr_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 64,
  parameter int MAX_BURST = 1,
  parameter int SEL_W     = $clog2(NUM_REQ)
) (
  input  logic                     CLK,
  input  logic                     Reset_n,
  input  logic [NUM_REQ-1:0]       i_ReqValid,
  input  logic [NUM_REQ*WIDTH-1:0] i_ReqData,
  output logic [NUM_REQ-1:0]       o_ReqGrant,
  output logic                     o_Valid,
  output logic [WIDTH-1:0]         o_Data,
  output logic [SEL_W-1:0]         o_GrantId,
  input  logic                     i_Ready
);

  logic [SEL_W-1:0]   owner_q, owner_d;
  logic [BEATS_W-1:0] beats_q, beats_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   data_q,  data_d;
  logic [SEL_W-1:0]   id_q,    id_d;

  logic               load;
  logic               sticky;
  logic [SEL_W-1:0]   start;
  logic [SEL_W-1:0]   winner;
  logic [NUM_REQ-1:0] pick_grant;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;
  logic [NUM_REQ-1:0] owner_onehot;
  logic [WIDTH-1:0]   req_word [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_word[gi] = i_ReqData[gi*WIDTH +: WIDTH];
  end

  // i_Ready reaches o_ReqGrant combinationally through load; no skid buffer.
  assign load  = !valid_q || i_Ready;
  assign start = (owner_q == SEL_W'(NUM_REQ - 1)) ? '0 : owner_q + SEL_W'(1);

  assign sticky = i_ReqValid[owner_q] && (beats_q != '0) &&
                  (beats_q < BEATS_W'(MAX_BURST));

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (SEL_W)
  ) u_pick (
    .req   (i_ReqValid),
    .start (start),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign winner = sticky ? owner_q : pick_idx;

  always_comb begin
    owner_onehot          = '0;
    owner_onehot[owner_q] = 1'b1;
  end

  always_comb begin
    o_ReqGrant = '0;
    if (Reset_n && load && pick_any) begin
      o_ReqGrant = sticky ? owner_onehot : pick_grant;
    end
  end

  always_comb begin
    owner_d = owner_q;
    beats_d = beats_q;
    valid_d = valid_q;
    data_d  = data_q;
    id_d    = id_q;
    if (load) begin
      if (pick_any) begin
        owner_d = winner;
        beats_d = sticky ? beats_q + BEATS_W'(1) : BEATS_W'(1);
        valid_d = 1'b1;
        data_d  = req_word[winner];
        id_d    = winner;
      end else begin
        // An idle slot ends the tenure; owner is kept as the rotation origin.
        valid_d = 1'b0;
        beats_d = '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      owner_q <= SEL_W'(NUM_REQ - 1);
      beats_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      owner_q <= owner_d;
      beats_q <= beats_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  assign o_Valid   = valid_q;
  assign o_Data    = data_q;
  assign o_GrantId = id_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed scoreboard bench for rr_grant_arbiter: one instance with
// MAX_BURST=1 for pure round-robin, one with MAX_BURST=3 for burst behaviour.
module tb_rr_grant_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [W-1:0]   req_data [N];
  logic [N*W-1:0] req_bus;
  logic           ready;

  logic [N-1:0] grant1, grant3;
  logic         valid1, valid3;
  logic [W-1:0] data1,  data3;
  logic [1:0]   id1,    id3;

  int errors = 0;
  int checks = 0;
  bit sel3   = 1'b0;

  typedef struct {
    logic [1:0]   id;
    logic [W-1:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign req_bus = {req_data[3], req_data[2], req_data[1], req_data[0]};

  rr_grant_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(1)) u_rr1 (
    .CLK        (clk),
    .Reset_n    (rst_n),
    .i_ReqValid (req_valid),
    .i_ReqData  (req_bus),
    .o_ReqGrant (grant1),
    .o_Valid    (valid1),
    .o_Data     (data1),
    .o_GrantId  (id1),
    .i_Ready    (ready)
  );

  rr_grant_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(3)) u_rr3 (
    .CLK        (clk),
    .Reset_n    (rst_n),
    .i_ReqValid (req_valid),
    .i_ReqData  (req_bus),
    .o_ReqGrant (grant3),
    .o_Valid    (valid3),
    .o_Data     (data3),
    .o_GrantId  (id3),
    .i_Ready    (ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] cur_grant();
    return sel3 ? grant3 : grant1;
  endfunction

  function automatic logic [1:0] idx_of(input logic [N-1:0] g);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  // One cycle: drive, check grant at negedge, push expectation, pop after edge.
  task automatic step(input logic [N-1:0] v, input logic rdy,
                      input logic [N-1:0] exp_grant, input string tag);
    exp_t e;
    req_valid = v;
    ready     = rdy;
    @(negedge clk);
    check({tag, ".grant"}, 32'(cur_grant()), 32'(exp_grant));
    if (exp_grant != '0) begin
      e.id   = idx_of(exp_grant);
      e.data = req_data[e.id];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (exp_grant != '0) begin
      e = sb.pop_front();
      check({tag, ".valid"}, 32'(sel3 ? valid3 : valid1), 32'd1);
      check({tag, ".id"},    32'(sel3 ? id3 : id1),       32'(e.id));
      check({tag, ".data"},  32'(sel3 ? data3 : data1),   32'(e.data));
      $display("txn %s: id=%0d data=%0h", tag, e.id, e.data);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    ready     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int ids_b [7] = '{0, 0, 0, 2, 2, 2, 0};

  initial begin
    for (int k = 0; k < N; k++) req_data[k] = 16'h1111 * 16'(k + 1);
    rst_n     = 1'b0;
    req_valid = '0;
    ready     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset.valid", 32'(valid3), 32'd0);
    check("reset.data",  32'(data3),  32'd0);
    check("reset.id",    32'(id3),    32'd0);
    req_valid = 4'hF;
    #1;
    check("reset.grant", 32'(grant3 | grant1), 32'd0);
    req_valid = '0;
    rst_n = 1'b1;

    // Pure round-robin, MAX_BURST=1.
    sel3 = 1'b0;
    for (int i = 0; i < 6; i++) step(4'hF, 1'b1, 4'(1 << (i % N)), "rr");

    // Burst limit, MAX_BURST=3.
    do_reset();
    sel3 = 1'b1;
    for (int i = 0; i < 7; i++) step(4'b0101, 1'b1, 4'(1 << ids_b[i]), "burst");

    // Early rotation when the owner's valid drops.
    do_reset();
    step(4'b1010, 1'b1, 4'b0010, "early");
    step(4'b1010, 1'b1, 4'b0010, "early");
    step(4'b1000, 1'b1, 4'b1000, "early");

    // Backpressure: hold 0xA5 for five stalled cycles.
    do_reset();
    req_data[0] = 16'h00A5;
    step(4'b0001, 1'b1, 4'b0001, "bp");
    req_data[0] = 16'h005A;
    for (int i = 0; i < 5; i++) begin
      req_valid = 4'b0001;
      ready     = 1'b0;
      @(negedge clk);
      check("bp.stall_grant", 32'(grant3), 32'd0);
      check("bp.stall_data",  32'(data3),  32'h00A5);
      check("bp.stall_valid", 32'(valid3), 32'd1);
      check("bp.stall_beats", 32'(u_rr3.beats_q), 32'd1);
      @(posedge clk);
      #1;
    end
    step(4'b0001, 1'b1, 4'b0001, "bp_resume");
    check("bp.beats_after", 32'(u_rr3.beats_q), 32'd2);

    // Idle cycle between requester 3 and requester 0 (wrap).
    do_reset();
    step(4'b1000, 1'b1, 4'b1000, "wrap");
    step(4'b0000, 1'b1, 4'b0000, "idle");
    check("idle.valid", 32'(valid3), 32'd0);
    check("idle.beats", 32'(u_rr3.beats_q), 32'd0);
    step(4'b0001, 1'b1, 4'b0001, "wrap");

    // Asynchronous reset mid-burst.
    do_reset();
    step(4'b0011, 1'b1, 4'b0001, "mid");
    req_valid = 4'b0011;
    ready     = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid", 32'(valid3), 32'd0);
    check("arst.grant", 32'(grant3), 32'd0);
    check("arst.data",  32'(data3),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b0110, 1'b1, 4'b0010, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
